// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: K-code constants, scheduler state enum and CRC-8 step shared by tx_link_scheduler (optional CRC via TX_SCHED_CRC_EN)
package tx_sched_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K28_0 = 8'h1C;
  typedef enum logic [2:0] {
    ST_TRAIN, ST_IDLE, ST_SOP, ST_CHID, ST_PAY,
`ifdef TX_SCHED_CRC_EN
    ST_CRC,
`endif
    ST_EOP
  } state_t;
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
endpackage

// File: rtl/tx_rr_arbiter.sv
// tx_rr_arbiter: combinational round-robin pick of the first requester after i_last
// ports: i_req (request vector), i_last (last granted index), o_grant (chosen index), o_any (any request)
module tx_rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [2:0]        i_last,
  output logic [2:0]        o_grant,
  output logic              o_any
);
  always_comb begin
    o_any = |i_req;
    o_grant = '0;
    // wrapped group first, then channels above i_last override so they take priority
    for (int k = NUM_CH - 1; k >= 0; k--) if (i_req[k] && 3'(k) <= i_last) o_grant = 3'(k);
    for (int k = NUM_CH - 1; k >= 0; k--) if (i_req[k] && 3'(k) > i_last) o_grant = 3'(k);
  end
endmodule

// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: per-symbol 8b/10b feeder with link training, RR packet framing, idle fill and comma realignment
// ports: pclk/reset (sync, active-high); req_valid/req_data/req_last/req_ready per-channel byte stream;
//        k_err/err_clr/err_sticky encoder error flag; tx_data/tx_kin encoder symbol; link_up; cur_ch owner
// define TX_SCHED_CRC_EN to append a CRC-8 symbol over CHID+payload before EOP
module tx_link_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TRAIN_LEN      = 64,
  parameter int ALIGN_INTERVAL = 256
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   req_valid,
  input  logic [NUM_CH*8-1:0] req_data,
  input  logic [NUM_CH-1:0]   req_last,
  output logic [NUM_CH-1:0]   req_ready,
  input  logic                k_err,
  input  logic                err_clr,
  output logic [7:0]          tx_data,
  output logic                tx_kin,
  output logic                link_up,
  output logic                err_sticky,
  output logic [2:0]          cur_ch
);
  localparam int TW = $clog2(TRAIN_LEN + 1);
  state_t        r_state;
  logic [TW-1:0] r_train_cnt;
  logic [8:0]    r_align_cnt;
  logic [2:0]    r_last_grant, r_cur_ch;
  logic [7:0]    r_tx_data;
  logic          r_tx_kin, r_link_up, r_err;
`ifdef TX_SCHED_CRC_EN
  logic [7:0]    r_crc;
`endif
  logic [2:0]    w_grant;
  logic          w_any, w_sel_valid, w_sel_last, w_align_due;
  logic [7:0]    w_sel_data;
  assign w_align_due = r_align_cnt >= 9'(ALIGN_INTERVAL - 1);
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last = 1'b0;
    w_sel_data = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_cur_ch == 3'(k)) begin
        w_sel_valid = req_valid[k];
        w_sel_last = req_last[k];
        w_sel_data = req_data[8*k +: 8];
      end
      req_ready[k] = r_state == ST_PAY && r_cur_ch == 3'(k);
    end
  end
  // at EOP the packet owner is the effective last grant for the back-to-back pick
  tx_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req  (req_valid),
    .i_last (r_state == ST_EOP ? r_cur_ch : r_last_grant),
    .o_grant(w_grant),
    .o_any  (w_any)
  );
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state <= ST_TRAIN;
      r_train_cnt <= '0;
      r_align_cnt <= '0;
      r_last_grant <= 3'(NUM_CH - 1);
      r_cur_ch <= '0;
      r_tx_data <= K28_5;
      r_tx_kin <= 1'b1;
      r_link_up <= 1'b0;
      r_err <= 1'b0;
`ifdef TX_SCHED_CRC_EN
      r_crc <= '0;
`endif
    end else begin
      r_err <= k_err | (r_err & ~err_clr);
      // commas are only emitted in TRAIN and IDLE, so those states restart the spacing count
      r_align_cnt <= (r_state == ST_TRAIN || r_state == ST_IDLE) ? '0 :
                     (&r_align_cnt) ? r_align_cnt : r_align_cnt + 9'd1;
      case (r_state)
        ST_TRAIN: begin
          r_tx_data <= K28_5;
          r_tx_kin <= 1'b1;
          r_train_cnt <= r_train_cnt + 1'b1;
          if (r_train_cnt == TW'(TRAIN_LEN - 1)) begin
            r_state <= ST_IDLE;
            r_link_up <= 1'b1;
          end
        end
        ST_IDLE: begin
          r_tx_data <= K28_5;
          r_tx_kin <= 1'b1;
          if (w_any) begin
            r_cur_ch <= w_grant;
            r_state <= ST_SOP;
          end
        end
        ST_SOP: begin
          r_tx_data <= K27_7;
          r_tx_kin <= 1'b1;
          r_state <= ST_CHID;
        end
        ST_CHID: begin
          r_tx_data <= {5'b0, r_cur_ch};
          r_tx_kin <= 1'b0;
`ifdef TX_SCHED_CRC_EN
          r_crc <= crc8_step(8'h00, {5'b0, r_cur_ch});
`endif
          r_state <= ST_PAY;
        end
        ST_PAY: begin
          r_tx_data <= w_sel_valid ? w_sel_data : K28_0;
          r_tx_kin <= ~w_sel_valid;
`ifdef TX_SCHED_CRC_EN
          if (w_sel_valid) r_crc <= crc8_step(r_crc, w_sel_data);
          if (w_sel_valid && w_sel_last) r_state <= ST_CRC;
        end
        ST_CRC: begin
          r_tx_data <= r_crc;
          r_tx_kin <= 1'b0;
          r_state <= ST_EOP;
`else
          if (w_sel_valid && w_sel_last) r_state <= ST_EOP;
`endif
        end
        ST_EOP: begin
          r_tx_data <= K29_7;
          r_tx_kin <= 1'b1;
          r_last_grant <= r_cur_ch;
          if (w_any && !w_align_due) begin
            r_cur_ch <= w_grant;
            r_state <= ST_SOP;
          end else r_state <= ST_IDLE;
        end
        default: r_state <= ST_TRAIN;
      endcase
    end
  end
  assign tx_data = r_tx_data;
  assign tx_kin = r_tx_kin;
  assign link_up = r_link_up;
  assign err_sticky = r_err;
  assign cur_ch = r_cur_ch;
endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: directed self-checking bench for tx_link_scheduler
module tb_tx_link_scheduler;
  logic        pclk = 1'b0, reset = 1'b1;
  logic [1:0]  req_valid = '0, req_last = '0, req_ready;
  logic [15:0] req_data = '0;
  logic        k_err = 1'b0, err_clr = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_kin, link_up, err_sticky;
  logic [2:0]  cur_ch;
  int ncmp = 0, nfail = 0;
  int gap0 = 0, acc0 = 0;
  logic [8:0] q0[$], q1[$], lg[$], ex[$];
`ifdef TX_SCHED_CRC_EN
  localparam int P = 5, NPK = 52;
`else
  localparam int P = 4, NPK = 64;
`endif
  tx_link_scheduler dut (
    .pclk(pclk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .k_err(k_err), .err_clr(err_clr),
    .tx_data(tx_data), .tx_kin(tx_kin), .link_up(link_up), .err_sticky(err_sticky),
    .cur_ch(cur_ch)
  );
  always #5 pclk = ~pclk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
  task automatic step();
    logic s0;
    @(negedge pclk);
    lg.push_back({tx_kin, tx_data});
    s0 = gap0 > 0 && acc0 == 2;
    if (s0) gap0--;
    req_valid[0] = q0.size() > 0 && !s0;
    {req_last[0], req_data[7:0]} = 9'h0;
    if (q0.size() > 0) {req_last[0], req_data[7:0]} = q0[0];
    req_valid[1] = q1.size() > 0;
    {req_last[1], req_data[15:8]} = 9'h0;
    if (q1.size() > 0) {req_last[1], req_data[15:8]} = q1[0];
    if (req_valid[0] && req_ready[0]) begin
      void'(q0.pop_front());
      acc0++;
    end
    if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
  endtask
  task automatic train(input string tag);
    int bad;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    gap0 = 0;
    acc0 = 0;
    step();
    step();
    chk({tag, "_rst_txd"}, tx_data, 8'hBC);
    chk({tag, "_rst_kin"}, tx_kin, 1);
    chk({tag, "_rst_rdy"}, req_ready, 0);
    chk({tag, "_rst_link"}, link_up, 0);
    chk({tag, "_rst_err"}, err_sticky, 0);
    chk({tag, "_rst_ch"}, cur_ch, 0);
    reset = 1'b0;
    lg.delete();
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 63) chk({tag, "_link63"}, link_up, 0);
      if (k == 64) chk({tag, "_link64"}, link_up, 1);
    end
    repeat (4) step();
    bad = 0;
    foreach (lg[i]) if (lg[i] !== 9'h1BC) bad++;
    chk({tag, "_non_comma"}, bad, 0);
  endtask
  task automatic cmp_seq(input string tag);
    int s;
    logic [8:0] o;
    s = -1;
    foreach (lg[i]) if (s < 0 && lg[i] !== 9'h1BC) s = i;
    if (s < 0) s = lg.size();
    foreach (ex[i]) begin
      o = 'x;
      if (s + i < lg.size()) o = lg[s+i];
      chk($sformatf("%s[%0d]", tag, i), {23'b0, o}, {23'b0, ex[i]});
    end
  endtask
  initial begin
    logic [7:0] c, d;
    logic [2:0] ch;
    int n, fd;
    // reset values and 64-comma training
    train("t1");
    // single 3-byte packet on ch0
    lg.delete();
    q0 = '{9'h011, 9'h022, 9'h133};
    repeat (14) step();
    ex = '{9'h1FB, 9'h000, 9'h011, 9'h022, 9'h033};
`ifdef TX_SCHED_CRC_EN
    c = crc8(crc8(crc8(crc8(8'h00, 8'h00), 8'h11), 8'h22), 8'h33);
    ex.push_back({1'b0, c});
`endif
    ex.push_back(9'h1FD);
    ex.push_back(9'h1BC);
    cmp_seq("t2");
    chk("t2_drained", q0.size(), 0);
    chk("t2_cur_ch", cur_ch, 0);
    chk("t2_rdy", req_ready, 0);
    // both channels streaming 1-byte packets: alternation then one comma at align_due
    lg.delete();
    for (int j = 0; j < 60; j++) begin
      q0.push_back({1'b1, 8'(8'h40 + j)});
      q1.push_back({1'b1, 8'(8'h80 + j)});
    end
    ex.delete();
    for (int p = 0; p < NPK; p++) begin
      ch = (p % 2 == 0) ? 3'd1 : 3'd0;
      d = ch[0] ? 8'(8'h80 + p / 2) : 8'(8'h40 + p / 2);
      ex.push_back(9'h1FB);
      ex.push_back({6'b0, ch});
      ex.push_back({1'b0, d});
`ifdef TX_SCHED_CRC_EN
      ex.push_back({1'b0, crc8(crc8(8'h00, {5'b0, ch}), d)});
`endif
      ex.push_back(9'h1FD);
    end
    ex.push_back(9'h1BC);
    ex.push_back(9'h1FB);
    repeat (NPK * P + 20) step();
    cmp_seq("t3");
    // stall for two cycles mid-packet
    train("t4r");
    lg.delete();
    q0 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h105};
    gap0 = 2;
    acc0 = 0;
    repeat (16) step();
    ex = '{9'h1FB, 9'h000, 9'h001, 9'h002, 9'h11C, 9'h11C, 9'h003, 9'h004, 9'h005};
`ifdef TX_SCHED_CRC_EN
    c = 8'h00;
    for (int j = 0; j <= 5; j++) c = crc8(c, 8'(j));
    ex.push_back({1'b0, c});
`endif
    ex.push_back(9'h1FD);
    ex.push_back(9'h1BC);
    cmp_seq("t4");
    chk("t4_drained", q0.size(), 0);
    // reset in the middle of a 10-byte packet
    lg.delete();
    for (int j = 0; j < 10; j++) q0.push_back({j == 9, 8'(8'hC0 + j)});
    acc0 = 0;
    n = 0;
    while (acc0 < 4 && n < 40) begin
      step();
      n++;
    end
    chk("t5_accepted", acc0, 4);
    chk("t5_in_pay", req_ready, 2'b01);
    reset = 1'b1;
    step();
    chk("t5_tx", {23'b0, lg[lg.size()-1]}, 32'h1BC);
    chk("t5_rdy", req_ready, 0);
    chk("t5_link", link_up, 0);
    chk("t5_cur_ch", cur_ch, 0);
    fd = 0;
    foreach (lg[i]) if (lg[i] === 9'h1FD) fd++;
    chk("t5_no_eop", fd, 0);
    train("t5t");
    // sticky error flag
    k_err = 1'b1;
    err_clr = 1'b1;
    step();
    k_err = 1'b0;
    err_clr = 1'b0;
    chk("t6_set_wins", err_sticky, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t6_clear", err_sticky, 0);
    k_err = 1'b1;
    step();
    k_err = 1'b0;
    step();
    chk("t6_first", err_sticky, 1);
    k_err = 1'b1;
    step();
    k_err = 1'b0;
    step();
    chk("t6_second", err_sticky, 1);
    chk("t6_link", link_up, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
